// File: rtl/pbs_ctrl_if.sv
// Signal bundle between the turn-sequencing controller and the battle datapath.
// The master side is the controller; the slave side is the datapath/environment.
interface pbs_ctrl_if #(
  parameter int unsigned TURN_W = 8
);
  logic              go;
  logic [1:0]        p_move_in;
  logic [3:0]        p_hp;
  logic [3:0]        AI_hp;
  logic [1:0]        p_move;
  logic              actr;
  logic              target;
  logic              calc_dmg;
  logic              app_dmg;
  logic              busy;
  logic              game_over;
  logic              winner;
  logic [TURN_W-1:0] turn_cnt;

  modport master (
    input  go, p_move_in, p_hp, AI_hp,
    output p_move, actr, target, calc_dmg, app_dmg, busy, game_over, winner, turn_cnt
  );

  modport slave (
    output go, p_move_in, p_hp, AI_hp,
    input  p_move, actr, target, calc_dmg, app_dmg, busy, game_over, winner, turn_cnt
  );
endinterface

// File: rtl/pbs_ctrl.sv
// Battle turn sequencer: player attack, KO check, AI attack, KO check per confirm.
// Phase outputs are Moore-decoded from the state register, so reset drops them at once.
module pbs_ctrl #(
  parameter int unsigned HOLD   = 3,
  parameter int unsigned TURN_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  pbs_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P_CALC   = 3'd1,
    S_P_APPLY  = 3'd2,
    S_P_CHK    = 3'd3,
    S_AI_CALC  = 3'd4,
    S_AI_APPLY = 3'd5,
    S_AI_CHK   = 3'd6,
    S_OVER     = 3'd7
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t            r_state;
  logic [3:0]        r_hold_cnt;
  logic              r_go_q;
  logic [1:0]        r_p_move;
  logic              r_winner;
  logic [TURN_W-1:0] r_turn_cnt;

  logic w_go_rise;
  logic w_hold_done;
  logic w_actr;
  logic w_target;
  logic w_calc;
  logic w_app;
  logic w_busy;
  logic w_over;

  assign w_go_rise   = bus.go & ~r_go_q;
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);

  // Turn sequencing state machine with latched move, winner and turn counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= 4'd0;
      r_go_q     <= 1'b0;
      r_p_move   <= 2'd0;
      r_winner   <= 1'b0;
      r_turn_cnt <= '0;
    end else begin
      r_go_q <= bus.go;
      case (r_state)
        S_IDLE: begin
          if (w_go_rise) begin
            r_p_move   <= bus.p_move_in;
            r_hold_cnt <= 4'd0;
            r_state    <= S_P_CALC;
          end
        end
        S_P_CALC, S_P_APPLY, S_AI_CALC, S_AI_APPLY: begin
          if (w_hold_done) begin
            r_hold_cnt <= 4'd0;
            case (r_state)
              S_P_CALC:  r_state <= S_P_APPLY;
              S_P_APPLY: r_state <= S_P_CHK;
              S_AI_CALC: r_state <= S_AI_APPLY;
              default:   r_state <= S_AI_CHK;
            endcase
          end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end
        S_P_CHK: begin
          // Player strikes first, so a double KO here is a player win
          if (bus.AI_hp == 4'd0) begin
            r_winner <= 1'b0;
            r_state  <= S_OVER;
          end else begin
            r_state  <= S_AI_CALC;
          end
        end
        S_AI_CHK: begin
          if (bus.p_hp == 4'd0) begin
            r_winner <= 1'b1;
            r_state  <= S_OVER;
          end else begin
            if (r_turn_cnt != {TURN_W{1'b1}}) begin
              r_turn_cnt <= r_turn_cnt + 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode of datapath controls from the current state
  always_comb begin
    w_actr   = 1'b0;
    w_target = 1'b1;
    w_calc   = 1'b0;
    w_app    = 1'b0;
    w_busy   = 1'b1;
    w_over   = 1'b0;
    case (r_state)
      S_IDLE:     w_busy = 1'b0;
      S_P_CALC:   w_calc = 1'b1;
      S_P_APPLY:  w_app  = 1'b1;
      S_P_CHK:    w_busy = 1'b1;
      S_AI_CALC:  begin w_actr = 1'b1; w_target = 1'b0; w_calc = 1'b1; end
      S_AI_APPLY: begin w_actr = 1'b1; w_target = 1'b0; w_app  = 1'b1; end
      S_AI_CHK:   begin w_actr = 1'b1; w_target = 1'b0; end
      S_OVER:     begin w_busy = 1'b0; w_over = 1'b1; end
      default:    w_busy = 1'b0;
    endcase
  end

  assign bus.p_move    = r_p_move;
  assign bus.actr      = w_actr;
  assign bus.target    = w_target;
  assign bus.calc_dmg  = w_calc;
  assign bus.app_dmg   = w_app;
  assign bus.busy      = w_busy;
  assign bus.game_over = w_over;
  assign bus.winner    = r_winner;
  assign bus.turn_cnt  = r_turn_cnt;

endmodule

// File: tb/tb_pbs_ctrl.sv
// Self-checking bench for pbs_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a turn-offset reference model.
module tb_pbs_ctrl;
  localparam int HOLD   = 3;
  localparam int TURN_W = 8;
  localparam int TURN_LEN = 4 * HOLD + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pbs_ctrl_if #(.TURN_W(TURN_W)) bus ();

  pbs_ctrl #(.HOLD(HOLD), .TURN_W(TURN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a turn is an offset counter walking through a 14-cycle schedule
  bit       m_over, m_winner, m_active, m_goq;
  int       m_off;
  int       m_turns;
  bit [1:0] m_move;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_over = 0; m_winner = 0; m_active = 0; m_goq = 0;
    m_off = 0; m_turns = 0; m_move = 2'd0;
  endtask

  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else begin
      if (!m_over) begin
        if (!m_active) begin
          if (bus.go && !m_goq) begin
            m_active = 1; m_off = 0; m_move = bus.p_move_in;
          end
        end else if (m_off == 2 * HOLD && bus.AI_hp == 4'd0) begin
          m_over = 1; m_winner = 0; m_active = 0;
        end else if (m_off == TURN_LEN - 1) begin
          if (bus.p_hp == 4'd0) begin
            m_over = 1; m_winner = 1;
          end else if (m_turns < (1 << TURN_W) - 1) begin
            m_turns++;
          end
          m_active = 0;
        end else begin
          m_off++;
        end
      end
      m_goq = bus.go;
    end
  endtask

  task automatic check_outputs();
    bit e_actr, e_tgt, e_calc, e_app, e_busy;
    e_actr = 0; e_tgt = 1; e_calc = 0; e_app = 0; e_busy = 0;
    if (m_active) begin
      e_busy = 1;
      if (m_off < HOLD)                e_calc = 1;
      else if (m_off < 2 * HOLD)       e_app  = 1;
      else if (m_off == 2 * HOLD)      e_calc = 0;
      else begin
        e_actr = 1; e_tgt = 0;
        if (m_off < 3 * HOLD + 1)      e_calc = 1;
        else if (m_off < 4 * HOLD + 1) e_app  = 1;
      end
    end
    chk("p_move",    32'(bus.p_move),    32'(m_move));
    chk("actr",      32'(bus.actr),      32'(e_actr));
    chk("target",    32'(bus.target),    32'(e_tgt));
    chk("calc_dmg",  32'(bus.calc_dmg),  32'(e_calc));
    chk("app_dmg",   32'(bus.app_dmg),   32'(e_app));
    chk("busy",      32'(bus.busy),      32'(e_busy));
    chk("game_over", 32'(bus.game_over), 32'(m_over));
    chk("winner",    32'(bus.winner),    32'(m_winner));
    chk("turn_cnt",  32'(bus.turn_cnt),  32'(m_turns));
  endtask

  task automatic drive(input bit g, input bit [1:0] mv, input bit [3:0] php, input bit [3:0] aihp);
    @(negedge clk);
    bus.go = g; bus.p_move_in = mv; bus.p_hp = php; bus.AI_hp = aihp;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    bus.go = 1'b0;
    rst = 1'b1;
  endtask

  task automatic run_idle(input int n, input bit [3:0] php, input bit [3:0] aihp);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'd0, php, aihp);
      tick();
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    bus.go = 1'b1; bus.p_move_in = 2'b11; bus.p_hp = 4'd7; bus.AI_hp = 4'd5;

    // Reset held with go high: idle outputs
    tick(); tick();
    chk("reset_target", 32'(bus.target), 32'd1);
    chk("reset_busy",   32'(bus.busy),   32'd0);
    do_reset();
    run_idle(3, 4'd7, 4'd5);

    // Normal turn, move 2'b10
    drive(1'b1, 2'b10, 4'd7, 4'd5);
    tick();
    chk("normal_move", 32'(bus.p_move), 32'd2);
    run_idle(TURN_LEN, 4'd7, 4'd5);
    chk("normal_turn_cnt", 32'(bus.turn_cnt), 32'd1);
    chk("normal_idle", 32'(bus.busy), 32'd0);

    // Player KO at P_CHK, with p_hp also zero: player wins, later go ignored
    do_reset();
    drive(1'b1, 2'b01, 4'd0, 4'd0);
    tick();
    run_idle(TURN_LEN + 2, 4'd0, 4'd0);
    chk("pko_over",   32'(bus.game_over), 32'd1);
    chk("pko_winner", 32'(bus.winner),    32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 4'd5, 4'd5); tick();
      drive(1'b0, 2'b11, 4'd5, 4'd5); tick();
    end

    // AI KO at AI_CHK
    do_reset();
    drive(1'b1, 2'b00, 4'd0, 4'd3);
    tick();
    run_idle(TURN_LEN + 2, 4'd0, 4'd3);
    chk("aiko_winner", 32'(bus.winner),   32'd1);
    chk("aiko_cnt",    32'(bus.turn_cnt), 32'd0);

    // go held 40 cycles, then pulse during AI_CALC, then a pulse in IDLE
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 2'b01, 4'd9, 4'd9); tick();
    end
    chk("held_go_cnt", 32'(bus.turn_cnt), 32'd1);
    drive(1'b0, 2'b01, 4'd9, 4'd9); tick();
    drive(1'b1, 2'b10, 4'd9, 4'd9); tick();
    for (int i = 0; i < 2 * HOLD + 1; i++) begin
      drive(1'b0, 2'b11, 4'd9, 4'd9); tick();
    end
    drive(1'b1, 2'b11, 4'd9, 4'd9); tick();
    run_idle(TURN_LEN, 4'd9, 4'd9);
    drive(1'b1, 2'b00, 4'd9, 4'd9); tick();
    run_idle(TURN_LEN, 4'd9, 4'd9);
    chk("second_turn_cnt", 32'(bus.turn_cnt), 32'd3);

    // Reset in AI_APPLY: app_dmg drops before the next clock edge
    do_reset();
    drive(1'b1, 2'b10, 4'd9, 4'd9); tick();
    for (int i = 0; i < 3 * HOLD + 2; i++) begin
      drive(1'b0, 2'b10, 4'd9, 4'd9); tick();
    end
    chk("pre_rst_app", 32'(bus.app_dmg), 32'd1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_app_drop", 32'(bus.app_dmg), 32'd0);
    check_outputs();
    do_reset();

    // Turn counter saturation
    for (int t = 0; t < (1 << TURN_W) + 2; t++) begin
      drive(1'b1, 2'(t), 4'd1, 4'd1); tick();
      run_idle(TURN_LEN, 4'd1, 4'd1);
    end
    chk("sat_cnt", 32'(bus.turn_cnt), 32'((1 << TURN_W) - 1));

    // Random stimulus with occasional KOs and resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit [3:0] php, aihp;
      php  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      aihp = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      drive(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), php, aihp);
      if ((m_over && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0) begin
        rst = 1'b0;
      end else begin
        rst = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
